// File: rtl/fp32_pkg.sv
// fp32_pkg
// Shared FP32 constants and the 28-bit aligned-sum layout used by the adder
// stage and by stage4_normalize_pack. Also holds the record that crosses the
// normalize -> round/pack pipeline register.
package fp32_pkg;

    localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;
    localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;
    localparam int          FP32_MAN_W   = 24;

    // 28-bit sum layout: [27] carry, [26] hidden, [25:3] fraction, [2:0] GRS
    localparam int SUM_W       = 28;
    localparam int SUM_CARRY   = 27;
    localparam int SUM_HIDDEN  = 26;
    localparam int SUM_FRAC_HI = 25;
    localparam int SUM_FRAC_LO = 3;
    localparam int SUM_GUARD   = 2;
    localparam int SUM_ROUND   = 1;
    localparam int SUM_STICKY  = 0;

    // Normalized word held between the two stages. man is the sum layout with
    // the carry bit dropped (always 0 after normalization).
    typedef struct packed {
        logic              sign;
        logic              nan;
        logic              inf;
        logic              zero;
        logic signed [9:0] exp;
        logic [26:0]       man;
    } norm_t;

endpackage

// File: rtl/lzc27.sv
// lzc27
// Combinational leading-zero counter over a 27-bit value.
// Ports:
//   value  in  27  value to scan, bit 26 is the most significant
//   count  out 5   number of leading zeros, 27 when value is all zero
module lzc27 (
    input  logic [26:0] value,
    output logic [4:0]  count
);

    // Scan upward; the highest set bit is the last to write the count.
    always_comb begin
        count = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (value[i]) begin
                count = 5'(26 - i);
            end
        end
    end

endmodule

// File: rtl/stage4_normalize_pack.sv
// stage4_normalize_pack
// Final stage of the FP32 add/subtract pipeline: normalizes the raw aligned
// sum, rounds to nearest-even and packs an IEEE-754 single result.
// Two register stages: s1 (normalized word) and s2 (packed result + flags).
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid/in_ready             upstream handshake
//   in_sign, in_exp, in_man       raw sum (sign, larger biased exp, 28-bit mag)
//   in_nan, in_inf                special-case overrides from earlier stages
//   out_valid/out_ready           downstream handshake
//   result                        packed FP32 word
//   flag_overflow/underflow/inexact  exception flags, qualified by out_valid
//
// Handshake: a word moves on a cycle where valid and ready are both high.
// valid never depends on ready; once out_valid is high, result and flags are
// held until out_ready takes them. in_ready is combinational from out_ready
// and the stage valids only.
module stage4_normalize_pack
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [27:0] in_man,
    input  logic        in_nan,
    input  logic        in_inf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        flag_overflow,
    output logic        flag_underflow,
    output logic        flag_inexact
);

    logic  s1_valid;
    norm_t s1;
    logic  s1_load;
    logic  s2_load;

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    // ---------------- Stage N: normalize ----------------
    logic [4:0]        lz;
    logic signed [9:0] e_eff;
    logic signed [9:0] e_lim;
    logic signed [9:0] lz_s;
    logic signed [9:0] shift;
    norm_t             n_next;

    lzc27 u_lzc (
        .value (in_man[SUM_HIDDEN:0]),
        .count (lz)
    );

    always_comb begin
        e_eff  = (in_exp == 8'd0) ? 10'sd1 : $signed({2'b00, in_exp});
        e_lim  = e_eff - 10'sd1;
        lz_s   = $signed({5'b00000, lz});
        // Never shift past exp 1: beyond that the value stays denormal.
        shift  = (lz_s < e_lim) ? lz_s : e_lim;
        n_next = '0;
        n_next.sign = in_sign;
        n_next.nan  = in_nan;
        n_next.inf  = in_inf;
        if (in_nan || in_inf) begin
            n_next.man = '0;
        end else if (in_man == '0) begin
            n_next.zero = 1'b1;
        end else if (in_man[SUM_CARRY]) begin
            // Right shift by one; the dropped bit folds into sticky.
            n_next.man = {in_man[SUM_CARRY:SUM_GUARD],
                          in_man[SUM_ROUND] | in_man[SUM_STICKY]};
            n_next.exp = e_eff + 10'sd1;
        end else begin
            n_next.man = in_man[SUM_HIDDEN:0] << shift[4:0];
            n_next.exp = e_eff - shift;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1 <= n_next;
            end
        end
    end

    // ---------------- Stage R: round and pack ----------------
    logic                  round_up;
    logic                  inexact;
    logic [FP32_MAN_W:0]   m_sum;
    logic [FP32_MAN_W-1:0] m_fin;
    logic signed [9:0]     e_rnd;
    logic [7:0]            exp_field;
    logic [31:0]           r_next;
    logic [2:0]            f_next;   // {overflow, underflow, inexact}

    always_comb begin
        round_up = s1.man[SUM_GUARD] &
                   (s1.man[SUM_ROUND] | s1.man[SUM_STICKY] | s1.man[SUM_FRAC_LO]);
        inexact  = |s1.man[SUM_GUARD:SUM_STICKY];
        m_sum    = {1'b0, s1.man[SUM_HIDDEN:SUM_FRAC_LO]} + {{FP32_MAN_W{1'b0}}, round_up};
        if (m_sum[FP32_MAN_W]) begin
            m_fin = m_sum[FP32_MAN_W:1];
            e_rnd = s1.exp + 10'sd1;
        end else begin
            m_fin = m_sum[FP32_MAN_W-1:0];
            e_rnd = s1.exp;
        end
        // A denormal (exp 1, hidden 0) that rounds into the hidden bit picks
        // up exp field 1 here with no special casing.
        exp_field = m_fin[FP32_MAN_W-1] ? e_rnd[7:0] : 8'h00;
        r_next    = {s1.sign, exp_field, m_fin[FP32_MAN_W-2:0]};
        f_next    = {1'b0, (exp_field == 8'h00) && inexact, inexact};
        if (e_rnd >= 10'sd255) begin
            r_next = {s1.sign, FP32_EXP_MAX, 23'h0};
            f_next = 3'b101;
        end
        if (s1.zero) begin
            r_next = {s1.sign, 31'h0};
            f_next = 3'b000;
        end
        if (s1.inf) begin
            r_next = {s1.sign, FP32_EXP_MAX, 23'h0};
            f_next = 3'b000;
        end
        if (s1.nan) begin
            r_next = FP32_QNAN;
            f_next = 3'b000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            result         <= 32'h0;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
            flag_inexact   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result                                        <= r_next;
                {flag_overflow, flag_underflow, flag_inexact} <= f_next;
            end else begin
                // Flags only mean something alongside out_valid.
                {flag_overflow, flag_underflow, flag_inexact} <= 3'b000;
            end
        end
    end

endmodule

// File: tb/tb_stage4_normalize_pack.sv
// tb_stage4_normalize_pack
// Directed bench for stage4_normalize_pack: a table of hand-computed vectors
// applied one at a time, then backpressure and mid-stream reset sequences.
module tb_stage4_normalize_pack;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [27:0] in_man;
    logic        in_nan;
    logic        in_inf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_overflow;
    logic        flag_underflow;
    logic        flag_inexact;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [27:0] man;
        logic        nan;
        logic        inf;
        logic [31:0] res;
        logic [2:0]  flags;   // {overflow, underflow, inexact}
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    stage4_normalize_pack dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sign        (in_sign),
        .in_exp         (in_exp),
        .in_man         (in_man),
        .in_nan         (in_nan),
        .in_inf         (in_inf),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .result         (result),
        .flag_overflow  (flag_overflow),
        .flag_underflow (flag_underflow),
        .flag_inexact   (flag_inexact)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic drive(input vec_t v);
        in_sign  = v.sign;
        in_exp   = v.exp;
        in_man   = v.man;
        in_nan   = v.nan;
        in_inf   = v.inf;
        in_valid = 1'b1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] flags_now();
        return {29'h0, flag_overflow, flag_underflow, flag_inexact};
    endfunction

    task automatic set_vec(input int i, input logic s, input logic [7:0] e,
                           input logic [27:0] m, input logic n, input logic f,
                           input logic [31:0] r, input logic [2:0] fl);
        vecs[i].sign  = s;
        vecs[i].exp   = e;
        vecs[i].man   = m;
        vecs[i].nan   = n;
        vecs[i].inf   = f;
        vecs[i].res   = r;
        vecs[i].flags = fl;
    endtask

    initial begin
        logic [31:0] exp_word;

        //        idx sign exp    man            nan   inf   result        flags
        set_vec(0,  0, 8'd127, 28'h8000000, 0, 0, 32'h40000000, 3'b000); // carry 1+1
        set_vec(1,  0, 8'd127, 28'h0000008, 0, 0, 32'h34000000, 3'b000); // cancel lz=23
        set_vec(2,  0, 8'd127, 28'h7FFFFFC, 0, 0, 32'h40000000, 3'b001); // tie, lsb 1, carry
        set_vec(3,  0, 8'd127, 28'h4000004, 0, 0, 32'h3F800000, 3'b001); // tie, lsb 0
        set_vec(4,  0, 8'd254, 28'hF000000, 0, 0, 32'h7F800000, 3'b101); // overflow via carry
        set_vec(5,  0, 8'd0,   28'h0000082, 0, 0, 32'h00000010, 3'b011); // denormal inexact
        set_vec(6,  1, 8'd127, 28'h0000000, 0, 0, 32'h80000000, 3'b000); // signed zero
        set_vec(7,  0, 8'd127, 28'h4000004, 1, 0, 32'h7FC00000, 3'b000); // NaN
        set_vec(8,  1, 8'd200, 28'h8000000, 0, 1, 32'hFF800000, 3'b000); // -inf
        set_vec(9,  1, 8'd5,   28'h1234567, 1, 1, 32'h7FC00000, 3'b000); // NaN beats inf
        set_vec(10, 0, 8'd0,   28'h3FFFFFE, 0, 0, 32'h00800000, 3'b001); // denorm rounds to normal
        set_vec(11, 0, 8'd127, 28'h6000001, 0, 0, 32'h3FC00000, 3'b001); // sticky only
        set_vec(12, 0, 8'd127, 28'h8000001, 0, 0, 32'h40000000, 3'b001); // carry shifts into sticky
        set_vec(13, 0, 8'd127, 28'h8000008, 0, 0, 32'h40000000, 3'b001); // carry, tie even
        set_vec(14, 0, 8'd127, 28'h8000018, 0, 0, 32'h40000002, 3'b001); // carry, tie odd
        set_vec(15, 1, 8'd254, 28'h7FFFFFC, 0, 0, 32'hFF800000, 3'b101); // overflow via rounding
        set_vec(16, 0, 8'd3,   28'h0000008, 0, 0, 32'h00000004, 3'b000); // shift clamped, exact
        set_vec(17, 1, 8'd130, 28'h5000000, 0, 0, 32'hC1200000, 3'b000); // plain normal

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = 8'd0;
        in_man    = 28'd0;
        in_nan    = 1'b0;
        in_inf    = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("reset_out_valid", {31'h0, out_valid}, 32'h0);
        check("reset_in_ready",  {31'h0, in_ready},  32'h1);
        check("reset_result",    result,             32'h0);
        check("reset_flags",     flags_now(),        32'h0);
        rst_n = 1'b1;

        // ---------------- table vectors ----------------
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            check($sformatf("v%0d_in_ready", i), {31'h0, in_ready}, 32'h1);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("v%0d_not_early", i), {31'h0, out_valid}, 32'h0);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_latency2", i), {31'h0, out_valid}, 32'h1);
            check($sformatf("v%0d_result", i),   result, vecs[i].res);
            check($sformatf("v%0d_flags", i),    flags_now(), {29'h0, vecs[i].flags});
        end

        // ---------------- backpressure: 2 buffered, 3rd refused ----------------
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        drive(vecs[0]);
        check("bp_w0_ready", {31'h0, in_ready}, 32'h1);
        exp_q.push_back(vecs[0].res);
        @(posedge clk);
        @(negedge clk);
        drive(vecs[1]);
        check("bp_w1_ready", {31'h0, in_ready}, 32'h1);
        exp_q.push_back(vecs[1].res);
        @(posedge clk);
        @(negedge clk);
        drive(vecs[3]);
        check("bp_w2_refused", {31'h0, in_ready},  32'h0);
        check("bp_out_valid",  {31'h0, out_valid}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp_hold%0d_ready", k),  {31'h0, in_ready}, 32'h0);
            check($sformatf("bp_hold%0d_result", k), result, exp_q[0]);
            check($sformatf("bp_hold%0d_flags", k),  flags_now(), 32'h0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_word = exp_q.pop_front();
            check($sformatf("bp_drain%0d_valid", k),  {31'h0, out_valid}, 32'h1);
            check($sformatf("bp_drain%0d_result", k), result, exp_word);
            @(posedge clk);
            @(negedge clk);
        end
        check("bp_no_dup",    {31'h0, out_valid}, 32'h0);
        check("bp_q_empty",   exp_q.size(),       32'h0);

        // ---------------- asynchronous reset mid-stream ----------------
        out_ready = 1'b0;
        drive(vecs[2]);
        @(posedge clk);
        @(negedge clk);
        drive(vecs[4]);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_pre_valid", {31'h0, out_valid}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_valid",  {31'h0, out_valid}, 32'h0);
        check("rst_async_ready",  {31'h0, in_ready},  32'h1);
        check("rst_async_result", result,             32'h0);
        check("rst_async_flags",  flags_now(),        32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("rst_no_stale%0d", k), {31'h0, out_valid}, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case something upstream of the fixed-length sequences hangs.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
